instr_stream_loader: RTL and testbench

Host-side controller that turns a 32-bit valid/ready word stream into complete 80-bit TPU instructions and writes them into the instruction FIFO. Each instruction is three stream words: lower, middle, then upper (upper word's low 16 bits only). It sequences the FIFO's three-part write interface and obeys the FIFO-full backpressure. It also provides flush, stall-timeout recovery, format-error flagging and a loaded-instruction counter.

---
 rtl/instr_stream_loader.sv | 104 ++++++++++
 tb/tb_instr_stream_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_loader.sv
// rtl/instr_stream_loader.sv - assembles three 32-bit stream words into one 80-bit instruction FIFO write
module instr_stream_loader #(
  parameter int COUNT_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            s_word,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   flush,
  input  logic                   err_clear,
  input  logic                   instr_fifo_full,
  output logic [31:0]            lower_instr_word,
  output logic [31:0]            middle_instr_word,
  output logic [15:0]            upper_instr_word,
  output logic [2:0]             instr_write_enable,
  output logic [COUNT_WIDTH-1:0] loaded_count,
  output logic                   busy,
  output logic                   fmt_err,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {W0, W1, W2, PUSH} state_t;

  // Counter only needs to hold TIMEOUT_CYCLES-1; the timeout fires on the idle cycle that would reach the limit.
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LIMIT = IW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic          xfer;
  logic          push;
  logic          partial;
  logic          timeout_hit;

  assign s_ready            = !rst && (state != PUSH) && !flush;
  assign xfer               = s_valid && s_ready;
  assign push               = (state == PUSH) && !instr_fifo_full && !flush;
  assign instr_write_enable = push ? 3'b111 : 3'b000;
  assign busy               = (state != W0);
  assign partial            = (state == W1) || (state == W2);
  assign timeout_hit        = (TIMEOUT_CYCLES > 0) && partial && !xfer && !flush &&
                              (idle_cnt == IDLE_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= W0;
      idle_cnt          <= '0;
      lower_instr_word  <= '0;
      middle_instr_word <= '0;
      upper_instr_word  <= '0;
      loaded_count      <= '0;
      fmt_err           <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      // Clear first so a same-cycle set event below wins.
      if (err_clear) begin
        fmt_err     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (push) loaded_count <= loaded_count + 1'b1;

      if (flush) begin
        state    <= W0;
        idle_cnt <= '0;
      end else begin
        case (state)
          W0: begin
            idle_cnt <= '0;
            if (xfer) begin
              lower_instr_word <= s_word;
              state            <= W1;
            end
          end
          W1, W2: begin
            if (xfer) begin
              idle_cnt <= '0;
              if (state == W1) begin
                middle_instr_word <= s_word;
                state             <= W2;
              end else begin
                upper_instr_word <= s_word[15:0];
                if (s_word[31:16] != 16'h0) fmt_err <= 1'b1;
                state <= PUSH;
              end
            end else if (timeout_hit) begin
              state       <= W0;
              idle_cnt    <= '0;
              timeout_err <= 1'b1;
            end else if (TIMEOUT_CYCLES > 0) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          PUSH: begin
            if (push) state <= W0;
          end
          default: state <= W0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_stream_loader.sv
// tb/tb_instr_stream_loader.sv - directed vector table plus timeout, wrap and reset sequences
module tb_instr_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_word;
  logic        s_valid;
  logic        s_ready;
  logic        flush;
  logic        err_clear;
  logic        instr_fifo_full;
  logic [31:0] lower_instr_word;
  logic [31:0] middle_instr_word;
  logic [15:0] upper_instr_word;
  logic [2:0]  instr_write_enable;
  logic [3:0]  loaded_count;
  logic        busy;
  logic        fmt_err;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int partial_we = 0;

  instr_stream_loader #(.COUNT_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .s_word(s_word), .s_valid(s_valid), .s_ready(s_ready),
    .flush(flush), .err_clear(err_clear), .instr_fifo_full(instr_fifo_full),
    .lower_instr_word(lower_instr_word), .middle_instr_word(middle_instr_word),
    .upper_instr_word(upper_instr_word), .instr_write_enable(instr_write_enable),
    .loaded_count(loaded_count), .busy(busy), .fmt_err(fmt_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (instr_write_enable != 3'b000) begin
      wr_cnt <= wr_cnt + 1;
      if (instr_write_enable != 3'b111) partial_we <= partial_we + 1;
    end
  end

  typedef struct {
    logic [31:0] word;
    logic        valid, full, flsh, clr;
    logic        e_rdy;
    logic [2:0]  e_we;
    logic        e_busy;
    logic [3:0]  e_cnt;
    logic        e_fmt, e_tmo;
    logic [31:0] e_lo, e_mid;
    logic [15:0] e_up;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] word, logic valid, logic full, logic flsh, logic clr,
                              logic e_rdy, logic [2:0] e_we, logic e_busy, logic [3:0] e_cnt,
                              logic e_fmt, logic e_tmo, logic [31:0] e_lo, logic [31:0] e_mid,
                              logic [15:0] e_up);
    vec_t v;
    v.word = word; v.valid = valid; v.full = full; v.flsh = flsh; v.clr = clr;
    v.e_rdy = e_rdy; v.e_we = e_we; v.e_busy = e_busy; v.e_cnt = e_cnt;
    v.e_fmt = e_fmt; v.e_tmo = e_tmo; v.e_lo = e_lo; v.e_mid = e_mid; v.e_up = e_up;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_word = 32'h0; s_valid = 1'b0; flush = 1'b0; err_clear = 1'b0; instr_fifo_full = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    s_word = w; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    //            word        v  f  fl cl  rdy we    busy cnt fmt tmo lo            mid           up
    vecs.push_back(mk(32'h11111111,1,0,0,0, 1,3'b000,0,4'd0,0,0,32'h0,        32'h0,        16'h0));
    vecs.push_back(mk(32'h22222222,1,0,0,0, 1,3'b000,1,4'd0,0,0,32'h11111111,32'h0,        16'h0));
    vecs.push_back(mk(32'h00003333,1,0,0,0, 1,3'b000,1,4'd0,0,0,32'h11111111,32'h22222222,16'h0));
    vecs.push_back(mk(32'h44444444,1,0,0,0, 0,3'b111,1,4'd0,0,0,32'h11111111,32'h22222222,16'h3333));
    vecs.push_back(mk(32'hAAAA0001,1,0,0,0, 1,3'b000,0,4'd1,0,0,32'h11111111,32'h22222222,16'h3333));
    vecs.push_back(mk(32'hBBBB0002,1,0,0,0, 1,3'b000,1,4'd1,0,0,32'hAAAA0001,32'h22222222,16'h3333));
    vecs.push_back(mk(32'hABCD1234,1,0,0,1, 1,3'b000,1,4'd1,0,0,32'hAAAA0001,32'hBBBB0002,16'h3333));
    vecs.push_back(mk(32'h0,       0,0,0,0, 0,3'b111,1,4'd1,1,0,32'hAAAA0001,32'hBBBB0002,16'h1234));
    vecs.push_back(mk(32'h0,       0,0,0,0, 1,3'b000,0,4'd2,1,0,32'hAAAA0001,32'hBBBB0002,16'h1234));
    vecs.push_back(mk(32'h0,       0,0,0,1, 1,3'b000,0,4'd2,1,0,32'hAAAA0001,32'hBBBB0002,16'h1234));
    vecs.push_back(mk(32'h0,       0,0,0,0, 1,3'b000,0,4'd2,0,0,32'hAAAA0001,32'hBBBB0002,16'h1234));
    vecs.push_back(mk(32'h01010101,1,0,0,0, 1,3'b000,0,4'd2,0,0,32'hAAAA0001,32'hBBBB0002,16'h1234));
    vecs.push_back(mk(32'h02020202,1,0,0,0, 1,3'b000,1,4'd2,0,0,32'h01010101,32'hBBBB0002,16'h1234));
    vecs.push_back(mk(32'h00000303,1,1,0,0, 1,3'b000,1,4'd2,0,0,32'h01010101,32'h02020202,16'h1234));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(32'hDEADBEEF,1,1,0,0, 0,3'b000,1,4'd2,0,0,32'h01010101,32'h02020202,16'h0303));
    vecs.push_back(mk(32'h0,       0,0,0,0, 0,3'b111,1,4'd2,0,0,32'h01010101,32'h02020202,16'h0303));
    vecs.push_back(mk(32'h0,       0,0,0,0, 1,3'b000,0,4'd3,0,0,32'h01010101,32'h02020202,16'h0303));
    vecs.push_back(mk(32'h0A0A0A0A,1,0,0,0, 1,3'b000,0,4'd3,0,0,32'h01010101,32'h02020202,16'h0303));
    vecs.push_back(mk(32'h0B0B0B0B,1,0,0,0, 1,3'b000,1,4'd3,0,0,32'h0A0A0A0A,32'h02020202,16'h0303));
    vecs.push_back(mk(32'h00000C0C,1,1,0,0, 1,3'b000,1,4'd3,0,0,32'h0A0A0A0A,32'h0B0B0B0B,16'h0303));
    vecs.push_back(mk(32'hFFFF0000,1,1,0,0, 0,3'b000,1,4'd3,0,0,32'h0A0A0A0A,32'h0B0B0B0B,16'h0C0C));
    vecs.push_back(mk(32'h12345678,1,0,1,0, 0,3'b000,1,4'd3,0,0,32'h0A0A0A0A,32'h0B0B0B0B,16'h0C0C));
    vecs.push_back(mk(32'h0,       0,0,0,0, 1,3'b000,0,4'd3,0,0,32'h0A0A0A0A,32'h0B0B0B0B,16'h0C0C));

    // Reset state
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_we", 32'(instr_write_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(loaded_count), 32'd0);
    chk("rst_lower", lower_instr_word, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      s_word = vecs[i].word; s_valid = vecs[i].valid; instr_fifo_full = vecs[i].full;
      flush = vecs[i].flsh; err_clear = vecs[i].clr;
      #1;
      chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_we", i), 32'(instr_write_enable), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_count", i), 32'(loaded_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_fmt_err", i), 32'(fmt_err), 32'(vecs[i].e_fmt));
      chk($sformatf("v%0d_timeout_err", i), 32'(timeout_err), 32'(vecs[i].e_tmo));
      chk($sformatf("v%0d_lower", i), lower_instr_word, vecs[i].e_lo);
      chk($sformatf("v%0d_middle", i), middle_instr_word, vecs[i].e_mid);
      chk($sformatf("v%0d_upper", i), 32'(upper_instr_word), 32'(vecs[i].e_up));
      step();
    end
    idle_inputs();
    chk("table_writes", 32'(wr_cnt), 32'd3);

    // Timeout: one word then eight idle cycles discards the partial instruction
    send(32'h77777777);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("tmo_busy_idle%0d", i), 32'(busy), 32'd1);
      step();
    end
    #1;
    chk("tmo_busy_after", 32'(busy), 32'd0);
    chk("tmo_err_set", 32'(timeout_err), 32'd1);
    chk("tmo_no_write", 32'(wr_cnt), 32'd3);
    send(32'h00000001);
    send(32'h00000002);
    send(32'h00000003);
    #1;
    chk("tmo_fresh_we", 32'(instr_write_enable), 32'h7);
    chk("tmo_fresh_lower", lower_instr_word, 32'h00000001);
    chk("tmo_fresh_upper", 32'(upper_instr_word), 32'h0003);
    step();
    chk("tmo_fresh_count", 32'(loaded_count), 32'd4);

    // Wrap: twelve more instructions bring the 4-bit count from 4 round to 0
    for (int i = 0; i < 12; i++) begin
      send(32'h100 + i);
      send(32'h200 + i);
      send(32'h300 + i);
      step();
    end
    #1;
    chk("wrap_count", 32'(loaded_count), 32'd0);
    chk("wrap_writes", 32'(wr_cnt), 32'd16);

    // Reset mid-instruction
    send(32'hCAFEF00D);
    send(32'hBEEFBEEF);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_lower", lower_instr_word, 32'd0);
    chk("midrst_middle", middle_instr_word, 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("midrst_writes", 32'(wr_cnt), 32'd16);
    chk("no_partial_we", 32'(partial_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
